// File: rtl/udp_csum_ctrl_if.sv
// Handshake and result bundle between the IP header parser / packet-accept
// logic (master side) and the UDP checksum sequencer (slave side).
interface udp_csum_ctrl_if;
   logic        i_start;
   logic [31:0] i_src_ip;
   logic [31:0] i_dst_ip;
   logic [15:0] i_udp_len;
   logic [15:0] i_data;
   logic        i_data_valid;
   logic        o_data_ready;
   logic        o_busy;
   logic        o_done;
   logic        o_checksum_valid;
   logic        o_csum_absent;
   logic        o_len_err;
   logic [15:0] o_sum;

   modport master (
      output i_start, i_src_ip, i_dst_ip, i_udp_len, i_data, i_data_valid,
      input  o_data_ready, o_busy, o_done, o_checksum_valid, o_csum_absent,
             o_len_err, o_sum
   );

   modport slave (
      input  i_start, i_src_ip, i_dst_ip, i_udp_len, i_data, i_data_valid,
      output o_data_ready, o_busy, o_done, o_checksum_valid, o_csum_absent,
             o_len_err, o_sum
   );
endinterface

// File: rtl/udp_csum_ctrl.sv
// UDP checksum verification sequencer: adds the IPv4 pseudo-header, then the
// UDP segment words, folds the 32-bit one's-complement accumulator to 16 bits
// and reports pass/fail. All outputs are registered, so each lags the state
// that produces it by one clock.
module udp_csum_ctrl #(
   parameter logic [7:0]  PROTO   = 8'h11,
   parameter int unsigned MIN_LEN = 8
) (
   input logic              i_clk,
   input logic              i_rst,
   udp_csum_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, PSEUDO, DATA, FOLD1, FOLD2, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] len_q, len_d;
   logic [31:0] acc_q, acc_d;
   logic [16:0] word_cnt_q, word_cnt_d;
   logic [16:0] word_idx_q, word_idx_d;
   logic [2:0]  pseudo_idx_q, pseudo_idx_d;
   logic        absent_flag_q, absent_flag_d;

   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        csum_valid_q, csum_valid_d;
   logic        csum_absent_q, csum_absent_d;
   logic        len_err_q, len_err_d;
   logic [15:0] sum_q, sum_d;

   logic        accept;
   logic        last_word;
   logic [15:0] pseudo_word;
   logic [15:0] data_word;

   // Handshake qualification and the word presented to the adder in DATA;
   // the pad byte of an odd-length segment lives in the low byte of the last word.
   always_comb begin
      accept    = (state_q == DATA) && ready_q && bus.i_data_valid;
      last_word = ((word_idx_q + 17'd1) == word_cnt_q);
      data_word = bus.i_data;
      if (last_word && len_q[0]) begin
         data_word = {bus.i_data[15:8], 8'h00};
      end
   end

   // Pseudo-header word selected by the PSEUDO step counter.
   always_comb begin
      pseudo_word = len_q;
      case (pseudo_idx_q)
         3'd0:    pseudo_word = src_q[31:16];
         3'd1:    pseudo_word = src_q[15:0];
         3'd2:    pseudo_word = dst_q[31:16];
         3'd3:    pseudo_word = dst_q[15:0];
         3'd4:    pseudo_word = {8'h00, PROTO};
         default: pseudo_word = len_q;
      endcase
   end

   // Next-state, accumulator and result computation for the whole sequencer.
   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      dst_d         = dst_q;
      len_d         = len_q;
      acc_d         = acc_q;
      word_cnt_d    = word_cnt_q;
      word_idx_d    = word_idx_q;
      pseudo_idx_d  = pseudo_idx_q;
      absent_flag_d = absent_flag_q;
      done_d        = 1'b0;
      csum_valid_d  = csum_valid_q;
      csum_absent_d = csum_absent_q;
      len_err_d     = len_err_q;
      sum_d         = sum_q;

      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               src_d         = bus.i_src_ip;
               dst_d         = bus.i_dst_ip;
               len_d         = bus.i_udp_len;
               acc_d         = 32'd0;
               word_cnt_d    = (17'(bus.i_udp_len) + 17'd1) >> 1;
               word_idx_d    = 17'd0;
               pseudo_idx_d  = 3'd0;
               absent_flag_d = 1'b0;
               csum_valid_d  = 1'b0;
               csum_absent_d = 1'b0;
               sum_d         = 16'd0;
               len_err_d     = (bus.i_udp_len < 16'(MIN_LEN));
               state_d       = (bus.i_udp_len < 16'(MIN_LEN)) ? DONE : PSEUDO;
            end
         end
         PSEUDO: begin
            acc_d        = acc_q + {16'h0000, pseudo_word};
            pseudo_idx_d = pseudo_idx_q + 3'd1;
            if (pseudo_idx_q == 3'd5) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               acc_d      = acc_q + {16'h0000, data_word};
               word_idx_d = word_idx_q + 17'd1;
               if (word_idx_q == 17'd3) begin
                  absent_flag_d = (bus.i_data == 16'h0000);
               end
               if (last_word) begin
                  state_d = FOLD1;
               end
            end
         end
         FOLD1: begin
            acc_d   = {16'h0000, acc_q[31:16]} + {16'h0000, acc_q[15:0]};
            state_d = FOLD2;
         end
         FOLD2: begin
            acc_d   = {16'h0000, acc_q[31:16]} + {16'h0000, acc_q[15:0]};
            state_d = DONE;
         end
         DONE: begin
            done_d = 1'b1;
            if (len_err_q) begin
               sum_d         = 16'd0;
               csum_valid_d  = 1'b0;
               csum_absent_d = 1'b0;
            end else if (absent_flag_q) begin
               sum_d         = acc_q[15:0];
               csum_valid_d  = 1'b1;
               csum_absent_d = 1'b1;
            end else begin
               sum_d         = acc_q[15:0];
               csum_valid_d  = (acc_q[15:0] == 16'hFFFF);
               csum_absent_d = 1'b0;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_q == DATA) && !(accept && last_word);
      busy_d  = (state_d != IDLE);
   end

   // State and output registers with synchronous reset that aborts any datagram.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= IDLE;
         src_q         <= 32'd0;
         dst_q         <= 32'd0;
         len_q         <= 16'd0;
         acc_q         <= 32'd0;
         word_cnt_q    <= 17'd0;
         word_idx_q    <= 17'd0;
         pseudo_idx_q  <= 3'd0;
         absent_flag_q <= 1'b0;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         csum_valid_q  <= 1'b0;
         csum_absent_q <= 1'b0;
         len_err_q     <= 1'b0;
         sum_q         <= 16'd0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         dst_q         <= dst_d;
         len_q         <= len_d;
         acc_q         <= acc_d;
         word_cnt_q    <= word_cnt_d;
         word_idx_q    <= word_idx_d;
         pseudo_idx_q  <= pseudo_idx_d;
         absent_flag_q <= absent_flag_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         csum_valid_q  <= csum_valid_d;
         csum_absent_q <= csum_absent_d;
         len_err_q     <= len_err_d;
         sum_q         <= sum_d;
      end
   end

   assign bus.o_data_ready     = ready_q;
   assign bus.o_busy           = busy_q;
   assign bus.o_done           = done_q;
   assign bus.o_checksum_valid = csum_valid_q;
   assign bus.o_csum_absent    = csum_absent_q;
   assign bus.o_len_err        = len_err_q;
   assign bus.o_sum            = sum_q;

endmodule

// File: tb/tb_udp_csum_ctrl.sv
// Self-checking bench for udp_csum_ctrl: directed datagrams followed by
// randomized ones, all compared against a plain-arithmetic checksum model.
module tb_udp_csum_ctrl;

   logic clock;
   logic reset;
   int   checkCount;
   int   failCount;
   logic [15:0] words[$];

   udp_csum_ctrl_if bus();

   udp_csum_ctrl #(.PROTO(8'h11), .MIN_LEN(8)) dut (
      .i_clk (clock),
      .i_rst (reset),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Expected result from the checksum rules: sum the pseudo-header and the
   // segment (pad byte zeroed), fold to 16 bits, then apply the pass rules.
   function automatic void refModel(input logic [31:0] src, input logic [31:0] dst,
                                    input logic [15:0] len, output logic [15:0] sum,
                                    output bit valid, output bit absent);
      longint acc;
      int nWords;
      logic [15:0] w;
      nWords = (int'(len) + 1) / 2;
      sum = 16'd0; valid = 1'b0; absent = 1'b0;
      if (len < 16'd8) return;
      acc = longint'(src[31:16]) + longint'(src[15:0]) + longint'(dst[31:16])
          + longint'(dst[15:0]) + 64'd17 + longint'(len);
      for (int i = 0; i < nWords; i++) begin
         w = words[i];
         if (i == nWords - 1 && len[0]) w[7:0] = 8'h00;
         acc += longint'(w);
      end
      while ((acc >> 16) != 0) acc = (acc & 64'hFFFF) + (acc >> 16);
      sum    = acc[15:0];
      absent = (words[3] == 16'h0000);
      valid  = absent || (sum == 16'hFFFF);
   endfunction

   // Present the next segment word and a valid level chosen by the pacing mode.
   task automatic driveData(input int idx, input int n, input int validMode, input int nWords);
      bus.i_data = (idx < nWords) ? words[idx] : 16'($urandom);
      case (validMode)
         0:       bus.i_data_valid = 1'b1;
         1:       bus.i_data_valid = ((n % 3) == 0);
         default: bus.i_data_valid = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Run one datagram through the DUT and check timing, word count and results.
   task automatic applyStimulus(input string name, input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] len, input int validMode,
                                input int abortAfter, input bit holdStart);
      int n, idx, firstReady, lastAccept, doneAt, budget, nWords, doneSeen;
      bit lenErr, acceptNow, readyLeak;
      logic [15:0] expSum;
      bit expValid, expAbsent;
      logic [15:0] heldSum;
      logic heldValid;

      nWords = (int'(len) + 1) / 2;
      lenErr = (len < 16'd8);
      refModel(src, dst, len, expSum, expValid, expAbsent);
      budget = 4 * nWords + 40;

      bus.i_src_ip = src; bus.i_dst_ip = dst; bus.i_udp_len = len;
      bus.i_start = 1'b1; bus.i_data_valid = 1'b0;
      @(posedge clock); #1;
      if (!holdStart) bus.i_start = 1'b0;
      n = 0; idx = 0; firstReady = -1; lastAccept = -1; doneAt = -1; readyLeak = 0;
      driveData(idx, n, validMode, nWords);

      while (doneAt < 0 && n < budget) begin
         acceptNow = bus.o_data_ready && bus.i_data_valid;
         @(posedge clock); #1;
         n++;
         if (n == 1) bus.i_start = 1'b0;
         if (acceptNow) begin idx++; lastAccept = n; end
         if (bus.o_data_ready && firstReady < 0) firstReady = n;
         if (bus.o_data_ready && idx >= nWords) readyLeak = 1'b1;
         if (bus.o_done) doneAt = n;
         if (abortAfter > 0 && idx == abortAfter) begin
            reset = 1'b1; bus.i_data_valid = 1'b0;
            @(posedge clock); #1;
            reset = 1'b0;
            checkOutput({name, "_rst_ready"}, 32'(bus.o_data_ready), 32'd0);
            checkOutput({name, "_rst_busy"},  32'(bus.o_busy), 32'd0);
            checkOutput({name, "_rst_flags"}, {28'd0, bus.o_done, bus.o_checksum_valid,
                                               bus.o_csum_absent, bus.o_len_err}, 32'd0);
            checkOutput({name, "_rst_sum"},   32'(bus.o_sum), 32'd0);
            doneSeen = 0;
            repeat (12) begin
               @(posedge clock); #1;
               if (bus.o_done) doneSeen++;
            end
            checkOutput({name, "_rst_no_done"}, 32'(doneSeen), 32'd0);
            return;
         end
         if (n == 1 && !lenErr) checkOutput({name, "_busy"}, 32'(bus.o_busy), 32'd1);
         driveData(idx, n, validMode, nWords);
      end
      bus.i_data_valid = 1'b0;

      if (lenErr) begin
         checkOutput({name, "_done_at"}, 32'(doneAt), 32'd1);
         checkOutput({name, "_ready_seen"}, 32'(firstReady), 32'hFFFF_FFFF);
         checkOutput({name, "_len_err"}, 32'(bus.o_len_err), 32'd1);
      end else begin
         checkOutput({name, "_first_ready"}, 32'(firstReady), 32'd7);
         checkOutput({name, "_done_lat"}, 32'(doneAt), 32'(lastAccept + 3));
         checkOutput({name, "_len_err"}, 32'(bus.o_len_err), 32'd0);
      end
      checkOutput({name, "_accepted"}, 32'(idx), lenErr ? 32'd0 : 32'(nWords));
      checkOutput({name, "_ready_leak"}, 32'(readyLeak), 32'd0);
      checkOutput({name, "_sum"}, 32'(bus.o_sum), 32'(expSum));
      checkOutput({name, "_valid"}, 32'(bus.o_checksum_valid), 32'(expValid));
      checkOutput({name, "_absent"}, 32'(bus.o_csum_absent), 32'(expAbsent));

      heldSum = bus.o_sum; heldValid = bus.o_checksum_valid;
      doneSeen = 0;
      repeat (3) begin
         @(posedge clock); #1;
         if (bus.o_done || bus.o_busy) doneSeen++;
      end
      checkOutput({name, "_idle_after"}, 32'(doneSeen), 32'd0);
      checkOutput({name, "_held"}, {15'd0, heldValid, heldSum},
                  {15'd0, bus.o_checksum_valid, bus.o_sum});
   endtask

   // Random segment; fieldMode 0 makes the checksum field correct, 1 zero, 2 random.
   task automatic buildRandom(input logic [15:0] len, input int fieldMode,
                              input logic [31:0] src, input logic [31:0] dst);
      int nWords;
      logic [15:0] s;
      bit v, a;
      nWords = (int'(len) + 1) / 2;
      words.delete();
      for (int i = 0; i < nWords; i++) words.push_back(16'($urandom));
      if (nWords >= 4 && fieldMode != 2) begin
         words[3] = 16'h0000;
         if (fieldMode == 0) begin
            refModel(src, dst, len, s, v, a);
            words[3] = ~s;
         end
      end
   endtask

   task automatic loadWords(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] w4, input int count);
      words.delete();
      words.push_back(w0); words.push_back(w1); words.push_back(w2); words.push_back(w3);
      if (count > 4) words.push_back(w4);
   endtask

   // Test sequence: reset state, directed datagrams, reset abort, random datagrams.
   initial begin
      logic [31:0] rSrc, rDst;
      logic [15:0] rLen;
      checkCount = 0; failCount = 0;
      reset = 1'b1;
      bus.i_start = 1'b0; bus.i_src_ip = '0; bus.i_dst_ip = '0; bus.i_udp_len = '0;
      bus.i_data = '0; bus.i_data_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_outputs", {24'd0, bus.o_data_ready, bus.o_busy, bus.o_done,
                  bus.o_checksum_valid, bus.o_csum_absent, bus.o_len_err, 2'd0}, 32'd0);
      checkOutput("reset_sum", 32'(bus.o_sum), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      loadWords(16'h1234, 16'h5678, 16'h0008, 16'h832F, 16'h0, 4);
      applyStimulus("t1_even", 32'h0A000001, 32'h0A000002, 16'd8, 0, 0, 1'b0);
      checkOutput("t1_sum_const", 32'(bus.o_sum), 32'h0000FFFF);

      loadWords(16'h1234, 16'h5678, 16'h0009, 16'hD82C, 16'hABCD, 5);
      applyStimulus("t2_odd", 32'h0A000001, 32'h0A000002, 16'd9, 0, 0, 1'b0);
      checkOutput("t2_sum_const", 32'(bus.o_sum), 32'h0000FFFF);

      loadWords(16'h1234, 16'h5678, 16'h0008, 16'h8330, 16'h0, 4);
      applyStimulus("t3_bad", 32'h0A000001, 32'h0A000002, 16'd8, 0, 0, 1'b0);
      checkOutput("t3_sum_const", 32'(bus.o_sum), 32'h00000001);

      loadWords(16'h1234, 16'h5678, 16'h0008, 16'h0000, 16'h0, 4);
      applyStimulus("t4_absent", 32'h0A000001, 32'h0A000002, 16'd8, 0, 0, 1'b0);
      checkOutput("t4_sum_const", 32'(bus.o_sum), 32'h00007CD0);

      words.delete();
      applyStimulus("t5_lenerr", 32'h0A000001, 32'h0A000002, 16'd5, 0, 0, 1'b1);

      loadWords(16'h1234, 16'h5678, 16'h0008, 16'h832F, 16'h0, 4);
      applyStimulus("t6_backpr", 32'h0A000001, 32'h0A000002, 16'd8, 1, 0, 1'b0);
      applyStimulus("t6_abort", 32'h0A000001, 32'h0A000002, 16'd8, 0, 2, 1'b0);
      applyStimulus("t6_fresh", 32'h0A000001, 32'h0A000002, 16'd8, 0, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         rSrc = $urandom; rDst = $urandom;
         rLen = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(8, 48));
         buildRandom(rLen, int'($urandom_range(0, 2)), rSrc, rDst);
         applyStimulus($sformatf("rand%0d", t), rSrc, rDst, rLen,
                       int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/udp_csum_ctrl.md
Name: udp_csum_ctrl

Overview:
Sequencer for UDP checksum verification. It injects the IPv4 pseudo-header, then accepts the UDP segment as a stream of 16-bit words under a valid/ready handshake and accumulates a one's-complement sum. It masks the pad byte of odd-length segments, folds carries, and reports pass/fail. It sits between the IP header parser, which supplies addresses and length, and the packet-accept logic.

Parameters:
PROTO, 8'h11, protocol byte placed in the pseudo-header.
MIN_LEN, 8, minimum legal UDP length in bytes (header only).

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_start  input  1  begin a datagram; samples i_src_ip, i_dst_ip, i_udp_len; honoured only in IDLE
i_src_ip  input  32  IPv4 source address
i_dst_ip  input  32  IPv4 destination address
i_udp_len  input  16  UDP length in bytes (header + payload)
i_data  input  16  segment word, big-endian: [15:8] is the first byte
i_data_valid  input  1  i_data valid
o_data_ready  output  1  high only in DATA
o_busy  output  1  low only in IDLE
o_done  output  1  one-cycle completion pulse
o_checksum_valid  output  1  checksum passed (or absent); held until next accepted i_start
o_csum_absent  output  1  transmitted checksum field was 0x0000
o_len_err  output  1  i_udp_len < MIN_LEN
o_sum  output  16  folded one's-complement sum; held until next accepted i_start

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - 32-bit accumulator and word counter cleared.
  - Reset in any state, including mid-DATA, aborts the datagram without an o_done pulse.
- States: IDLE, PSEUDO, DATA, FOLD1, FOLD2, DONE.
- IDLE:
  - On i_start, latch the inputs, clear acc and the result outputs, and load word count = ceil(i_udp_len/2).
  - If i_udp_len < MIN_LEN, go to DONE with o_len_err=1.
  - Otherwise go to PSEUDO.
- PSEUDO: exactly 6 cycles. One word added per cycle, in this order: src[31:16], src[15:0], dst[31:16], dst[15:0], {8'h00,PROTO}, udp_len. o_data_ready=0.
- DATA:
  - A word is accepted when i_data_valid && o_data_ready. No accept leaves acc unchanged; valid may drop arbitrarily.
  - Each accepted word is zero-extended and added to acc.
  - On the final word, if i_udp_len is odd, bits [7:0] are masked to 0 before the add.
  - Accepted word index 3 (the checksum field) is compared to 0x0000 and the flag is latched.
  - After the final accept, go to FOLD1. Words beyond the count are never accepted (ready drops).
- Arithmetic:
  - Max sum is (6+32768)*0xFFFF < 2^32, so acc never overflows.
  - FOLD1 and FOLD2 each perform acc <= acc[31:16] + acc[15:0]. Both always run (fixed latency); the result fits 16 bits after FOLD2.
- DONE (1 cycle):
  - o_done=1; o_sum=acc[15:0].
  - If the absent flag is set: o_checksum_valid=1, o_csum_absent=1.
  - Otherwise: o_checksum_valid=(acc[15:0]==16'hFFFF).
  - On o_len_err: o_checksum_valid=0, o_sum=0.
  - Next state is IDLE. i_start during DONE is ignored.
- Latency:
  - i_start edge to first o_data_ready = 7 cycles.
  - Final-word accept edge to o_done = 3 cycles.
  - Length-error path: o_done in the cycle after the i_start edge.

Test Plan:
1. Valid, even length. src=0A000001, dst=0A000002, len=8; words 1234,5678,0008,832F (valid every cycle) -> o_sum=FFFF, o_checksum_valid=1, o_csum_absent=0, o_done 3 cycles after the last accept, first ready 7 cycles after start.
2. Odd length with pad mask. Same addresses, len=9; words 1234,5678,0009,D82C,ABCD -> pad byte CD ignored, o_sum=FFFF, valid=1; exactly 5 words accepted, ready low afterward.
3. Bad checksum. As test 1 but field=8330 -> o_sum=0001, o_checksum_valid=0.
4. Absent checksum. As test 1 but field=0000 -> o_csum_absent=1, o_checksum_valid=1, o_sum=7CD0.
5. Length error. i_start with len=5 -> o_done, o_len_err=1, valid=0 one cycle later; ready never asserted. Also: i_start held during DONE is ignored.
6. Backpressure and reset. Test 1 with i_data_valid toggling 1,0,0,1,... gives the same result. Then i_rst mid-DATA after 2 words -> all outputs 0, no o_done; a fresh test-1 run passes.
